// File: rtl/ws2812b_frame_streamer_pkg.sv
// Shared definitions for the WS2812B frame streamer: FSM encoding and GRB word layout.
package ws2812b_frame_streamer_pkg;

  localparam int WORD_W = 24;
  localparam int CH_W   = 8;
  localparam int G_LSB  = 16;
  localparam int R_LSB  = 8;
  localparam int B_LSB  = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_OFFER,
    S_WAIT_LOW
  } state_t;

endpackage

// File: rtl/ws2812b_frame_streamer_grb_scale.sv
// Brightness scaler: each 8-bit GRB channel is shifted right independently.
module ws2812b_frame_streamer_grb_scale
  import ws2812b_frame_streamer_pkg::*;
(
  input  logic [WORD_W-1:0] color,
  input  logic [2:0]        shift,
  output logic [WORD_W-1:0] scaled
);

  // Shifting per slice keeps the upper channel's low bits out of the lower channel.
  always_comb begin
    scaled = '0;
    scaled[G_LSB +: CH_W] = color[G_LSB +: CH_W] >> shift;
    scaled[R_LSB +: CH_W] = color[R_LSB +: CH_W] >> shift;
    scaled[B_LSB +: CH_W] = color[B_LSB +: CH_W] >> shift;
  end

endmodule

// File: rtl/ws2812b_frame_streamer.sv
// Walks the LED matrix in strip order, reads the 1-bpp framebuffer and hands
// brightness-scaled GRB words to the WS2812B driver over valid/ready.
module ws2812b_frame_streamer
  import ws2812b_frame_streamer_pkg::*;
#(
  parameter int COLS       = 8,
  parameter int ROWS       = 8,
  parameter int SERPENTINE = 1,
  parameter int ADDR_W     = 6
) (
  input  logic              clk20,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] fg_color,
  input  logic [WORD_W-1:0] bg_color,
  input  logic [2:0]        brightness,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              pix_rd,
  input  logic              pix_data,
  output logic [WORD_W-1:0] led_data,
  output logic              led_valid,
  output logic              led_latch,
  input  logic              led_ready,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);

  state_t            state;
  logic [WORD_W-1:0] fg_sh;
  logic [WORD_W-1:0] bg_sh;
  logic [2:0]        br_sh;
  logic [ADDR_W-1:0] row;
  logic [ADDR_W-1:0] col;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] nxt_row;
  logic [ADDR_W-1:0] nxt_col;
  logic [ADDR_W-1:0] nxt_base;
  logic [WORD_W-1:0] scaled;
  logic              last;

  // row_base tracks row*COLS incrementally so no multiplier is needed.
  function automatic logic [ADDR_W-1:0] map_addr(input logic [ADDR_W-1:0] base,
                                                 input logic [ADDR_W-1:0] r,
                                                 input logic [ADDR_W-1:0] c);
    if (SERPENTINE != 0 && r[0])
      return base + (COL_LAST - c);
    else
      return base + c;
  endfunction

  ws2812b_frame_streamer_grb_scale grb_scale (
    .color  (pix_data ? fg_sh : bg_sh),
    .shift  (br_sh),
    .scaled (scaled)
  );

  assign last = (row == ROW_LAST) && (col == COL_LAST);

  always_comb begin
    nxt_col  = col + 1'b1;
    nxt_row  = row;
    nxt_base = row_base;
    if (col == COL_LAST) begin
      nxt_col  = '0;
      nxt_row  = row + 1'b1;
      nxt_base = row_base + COLS_A;
    end
  end

  always_ff @(posedge clk20) begin
    if (reset) begin
      state      <= S_IDLE;
      fg_sh      <= '0;
      bg_sh      <= '0;
      br_sh      <= '0;
      row        <= '0;
      col        <= '0;
      row_base   <= '0;
      pix_addr   <= '0;
      pix_rd     <= 1'b0;
      led_data   <= '0;
      led_valid  <= 1'b0;
      led_latch  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      pix_rd     <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          // busy is still high during the frame_done cycle, so a start there is dropped.
          busy <= 1'b0;
          if (start && !busy) begin
            fg_sh    <= fg_color;
            bg_sh    <= bg_color;
            br_sh    <= brightness;
            row      <= '0;
            col      <= '0;
            row_base <= '0;
            pix_addr <= '0;
            pix_rd   <= 1'b1;
            busy     <= 1'b1;
            state    <= S_FETCH;
          end
        end
        S_FETCH: state <= S_CAPTURE;
        S_CAPTURE: begin
          led_data  <= scaled;
          led_latch <= last;
          led_valid <= 1'b1;
          state     <= S_OFFER;
        end
        S_OFFER: begin
          if (led_ready) begin
            led_valid <= 1'b0;
            state     <= S_WAIT_LOW;
          end
        end
        S_WAIT_LOW: begin
          // The driver's registered ready lingers one cycle after acceptance.
          if (!led_ready) begin
            if (led_latch) begin
              frame_done <= 1'b1;
              led_latch  <= 1'b0;
              state      <= S_IDLE;
            end else begin
              col      <= nxt_col;
              row      <= nxt_row;
              row_base <= nxt_base;
              pix_addr <= map_addr(nxt_base, nxt_row, nxt_col);
              pix_rd   <= 1'b1;
              state    <= S_FETCH;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
